// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling constants and the
// baud divider used by both the receiver and the future transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_e;

  localparam int OS         = 16;
  localparam int SAMPLE_MID = 8;

  // Clock cycles per oversample tick, rounded to nearest.
  function automatic int baud_div(input longint clk_hz, input longint baud);
    return int'((clk_hz + baud * 8) / (baud * 16));
  endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_if;
  logic       rdy_clr;
  logic [7:0] dout;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (input rdy_clr, output dout, rdy, frame_err, overrun, busy);
  modport slave  (output rdy_clr, input dout, rdy, frame_err, overrun, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick at 16x the baud rate.
// Never realigned to the data; the receiver tolerates 1/16 bit of jitter.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_div_chk
    $error("uart_baud_tick: clock too slow for requested baud rate");
  end

  logic [CW-1:0] cnt;

  // Divider counter, wraps at DIV-1 (stays at 0 when DIV is 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (cnt == CW'(DIV - 1))   cnt <= '0;
    else                            cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver, 8N1, 3-sample majority vote per bit,
// false-start rejection, sticky framing/overrun flags, level rdy handshake.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int OS     = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rx,
  uart_rx_if.master bus
);

  if (OS != uart_pkg::OS) begin : g_os_chk
    $error("uart_rx_os16: OS must be 16");
  end

  localparam logic [3:0] SC_S0  = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] SC_S1  = 4'(SAMPLE_MID);
  localparam logic [3:0] SC_DEC = 4'(SAMPLE_MID + 1);

  logic        rx_s1, rxs, tick;
  uart_state_e state, state_nxt;
  logic [3:0]  sc;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [1:0]  smp;
  logic        maj, decide, deliver, ferr_evt;
  logic [7:0]  dout_q;
  logic        rdy_q, ferr_q, ovr_q;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
    end
  end

  uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Third sample is the live value on the deciding tick.
  assign maj    = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign decide = tick && (sc == SC_DEC);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the delivery / framing-error events.
  always_comb begin
    state_nxt = state;
    deliver   = 1'b0;
    ferr_evt  = 1'b0;
    case (state)
      IDLE:  if (tick && !rxs) state_nxt = START;
      START: begin
        if (decide && maj)              state_nxt = IDLE;
        else if (tick && sc == 4'd15)   state_nxt = DATA;
      end
      DATA:  if (tick && sc == 4'd15 && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (decide) begin
        if (maj) begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end else begin
          ferr_evt  = 1'b1;
          state_nxt = BREAK;
        end
      end
      BREAK: if (tick && rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sample counter, vote samples, bit index and data shift register.
  // Parking sc at 1 outside a frame means START begins at sample 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc      <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      smp     <= '0;
    end else if (tick) begin
      if (state == IDLE || state == BREAK) sc <= 4'd1;
      else                                 sc <= sc + 4'd1;
      if (sc == SC_S0) smp[0] <= rxs;
      if (sc == SC_S1) smp[1] <= rxs;
      if (state == START) bit_idx <= '0;
      if (state == DATA && sc == SC_DEC) shreg   <= {maj, shreg[7:1]};
      if (state == DATA && sc == 4'd15)  bit_idx <= bit_idx + 3'd1;
    end
  end

  // Consumer-visible registers; a same-cycle event beats rdy_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      rdy_q  <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (deliver && (!rdy_q || bus.rdy_clr)) begin
        dout_q <= shreg;
        rdy_q  <= 1'b1;
      end else if (bus.rdy_clr) begin
        rdy_q  <= 1'b0;
      end
      if (deliver && rdy_q && !bus.rdy_clr) ovr_q <= 1'b1;
      else if (bus.rdy_clr)                 ovr_q <= 1'b0;
      if (ferr_evt)         ferr_q <= 1'b1;
      else if (bus.rdy_clr) ferr_q <= 1'b0;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at 32 clk/bit. Stimulus pushes expected
// bytes into a queue; a monitor pops and compares on every rdy rise.
module tb_uart_rx_os16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   start_cyc = 0;
  int   rise_cyc = -1;
  logic rdy_q = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_if bus_if ();

  uart_rx_os16 #(.CLK_HZ(3200000), .BAUD(100000), .OS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: each rdy rise must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && bus_if.rdy && !rdy_q) begin
      rise_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rdy: got dout 0x%0h expected no byte", bus_if.dout);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (bus_if.dout !== e) begin
          errors++;
          $display("FAIL rx_byte: got 0x%0h expected 0x%0h", bus_if.dout, e);
        end
      end
    end
    rdy_q = bus_if.rdy;
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 8N1 frame, LSB first; the stop level is held for stop_clks and left on rx.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_clks);
    rx = 1'b0;
    start_cyc = cyc;
    tick_n(32);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick_n(32);
    end
    rx = stop_lvl;
    tick_n(stop_clks);
  endtask

  task automatic pulse_clr();
    bus_if.rdy_clr = 1'b1;
    tick_n(1);
    bus_if.rdy_clr = 1'b0;
  endtask

  initial begin
    int saw_busy, last_busy, busy_bad;
    rst_n = 1'b0;
    rx = 1'b1;
    bus_if.rdy_clr = 1'b0;
    @(negedge clk);

    // 1. reset state, then idle line
    tick_n(5);
    check("rst_dout", bus_if.dout, 8'h00);
    check("rst_rdy", bus_if.rdy, 1'b0);
    check("rst_frame_err", bus_if.frame_err, 1'b0);
    check("rst_overrun", bus_if.overrun, 1'b0);
    check("rst_busy", bus_if.busy, 1'b0);
    rst_n = 1'b1;
    busy_bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick_n(1);
      if (bus_if.busy) busy_bad = 1;
    end
    check("idle_busy", busy_bad, 0);

    // 2. single byte, latency, clear
    rise_cyc = -1;
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1, 32);
    check_range("lat_0x41", rise_cyc - start_cyc, 306, 312);
    check("b41_rdy", bus_if.rdy, 1'b1);
    check("b41_frame_err", bus_if.frame_err, 1'b0);
    pulse_clr();
    check("b41_rdy_clr", bus_if.rdy, 1'b0);
    tick_n(20);

    // 3. 6-clk low glitch: false start
    saw_busy = 0;
    last_busy = 0;
    rx = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick_n(1);
      if (i == 6) rx = 1'b1;
      if (bus_if.busy) begin
        saw_busy = 1;
        last_busy = i;
      end
    end
    check("glitch_saw_busy", saw_busy, 1);
    check_range("glitch_busy_off", last_busy, 1, 21);
    check("glitch_rdy", bus_if.rdy, 1'b0);
    check("glitch_dout", bus_if.dout, 8'h41);

    // 4. stop bit held low 64 clk -> framing error, break
    send_frame(8'h55, 1'b0, 62);
    check("ferr_set", bus_if.frame_err, 1'b1);
    check("ferr_rdy", bus_if.rdy, 1'b0);
    check("ferr_dout", bus_if.dout, 8'h41);
    check("ferr_busy_break", bus_if.busy, 1'b1);
    tick_n(2);
    rx = 1'b1;
    tick_n(12);
    check("ferr_busy_idle", bus_if.busy, 1'b0);
    pulse_clr();
    check("ferr_clr", bus_if.frame_err, 1'b0);
    tick_n(40);

    // 5. back-to-back without clear -> overrun; then clear and new byte
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 32);
    send_frame(8'h34, 1'b1, 32);
    check("ovr_rdy", bus_if.rdy, 1'b1);
    check("ovr_set", bus_if.overrun, 1'b1);
    check("ovr_dout", bus_if.dout, 8'h12);
    pulse_clr();
    check("ovr_clr_rdy", bus_if.rdy, 1'b0);
    exp_q.push_back(8'h56);
    send_frame(8'h56, 1'b1, 32);
    check("ovr_after_clr", bus_if.overrun, 1'b0);
    check("b56_dout", bus_if.dout, 8'h56);
    tick_n(20);

    // 6. reset during data bit 4 of 0xFF, then 0xA5
    rx = 1'b0;
    tick_n(32);
    rx = 1'b1;
    tick_n(4 * 32 + 16);
    rst_n = 1'b0;
    #1;
    check("midrst_dout", bus_if.dout, 8'h00);
    check("midrst_rdy", bus_if.rdy, 1'b0);
    check("midrst_busy", bus_if.busy, 1'b0);
    tick_n(3);
    rst_n = 1'b1;
    tick_n(300);
    check("aborted_rdy", bus_if.rdy, 1'b0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 32);
    tick_n(10);
    check("bA5_rdy", bus_if.rdy, 1'b1);

    check("pending_bytes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
